mem_req_arbiter: RTL

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter_pkg.sv | 15 +
 rtl/mem_req_arbiter_rr_pick.sv | 29 ++
 rtl/mem_req_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared DDR definitions for the memory request arbiter: arbiter state
// encodings, burst length width and watchdog width.
package mem_req_arbiter_pkg;

    localparam int BURST_LEN_W = 8;
    localparam int WDOG_W      = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_BUSY  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_req_arbiter_rr_pick.sv
// Round-robin picker: returns the first requesting port after last_winner,
// wrapping from PORT_NUM-1 back to 0. Purely combinational.
module rr_pick #(
    parameter int PORT_NUM = 4,
    parameter int IDX_W    = $clog2(PORT_NUM)
) (
    input  logic [PORT_NUM-1:0] req,
    input  logic [IDX_W-1:0]    last_winner,
    output logic [PORT_NUM-1:0] winner
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // scan last_winner+1 .. last_winner+PORT_NUM, first hit wins
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= PORT_NUM; i++) begin
            idx = IDX_W'((int'(last_winner) + i) % PORT_NUM);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Multi-port DDR burst arbiter: grants one requester at a time (round-robin),
// forwards its command to the read or write burst controller and routes the
// data beats back to the owner. At most one burst is outstanding.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | no owner; waiting for calibration done and a request
// ARB_ISSUE | owner latched; one-cycle rd/wr command to the controller
// ARB_BUSY  | burst in flight; data routed, watchdog counting down
// ARB_DONE  | one-cycle done (and err on timeout/abort) pulse to owner
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int PORT_NUM      = 4,
    parameter int MEM_DATA_BITS = 256,
    parameter int ADDR_WIDTH    = 30,
    parameter int TIMEOUT_CYC   = 4096
) (
    input  logic                              ddr_clk_i,
    input  logic                              ddr_rst_n_i,
    input  logic                              local_init_done_i,
    input  logic [PORT_NUM-1:0]               port_req_i,
    input  logic [PORT_NUM-1:0]               port_wr_i,
    input  logic [PORT_NUM*BURST_LEN_W-1:0]   port_len_i,
    input  logic [PORT_NUM*ADDR_WIDTH-1:0]    port_addr_i,
    input  logic [PORT_NUM*MEM_DATA_BITS-1:0] port_wdata_i,
    output logic [PORT_NUM-1:0]               port_grant_o,
    output logic [PORT_NUM-1:0]               port_wdata_req_o,
    output logic [PORT_NUM-1:0]               port_rdata_valid_o,
    output logic [MEM_DATA_BITS-1:0]          port_rdata_o,
    output logic [PORT_NUM-1:0]               port_done_o,
    output logic [PORT_NUM-1:0]               port_err_o,
    output logic                              rd_ddr_req_o,
    output logic [BURST_LEN_W-1:0]            rd_ddr_len_o,
    output logic [ADDR_WIDTH-1:0]             rd_ddr_addr_o,
    input  logic                              rd_ddr_data_valid_i,
    input  logic [MEM_DATA_BITS-1:0]          rd_ddr_data_i,
    input  logic                              rd_ddr_finish_i,
    output logic                              wr_ddr_req_o,
    output logic [BURST_LEN_W-1:0]            wr_ddr_len_o,
    output logic [ADDR_WIDTH-1:0]             wr_ddr_addr_o,
    output logic [MEM_DATA_BITS-1:0]          wr_ddr_data_o,
    input  logic                              wr_ddr_data_req_i,
    input  logic                              wr_ddr_finish_i
);

    localparam int                IDX_W     = $clog2(PORT_NUM);
    localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(TIMEOUT_CYC - 1);

    arb_state_e               state_q, state_d;
    logic [PORT_NUM-1:0]      owner_q, win;
    logic [IDX_W-1:0]         owner_idx_q, last_winner_q, win_idx;
    logic [BURST_LEN_W-1:0]   len_q, win_len;
    logic [ADDR_WIDTH-1:0]    addr_q, win_addr;
    logic                     wr_q, win_wr, err_q, err_d, fwd;
    logic [WDOG_W-1:0]        wdog_q;
    logic [MEM_DATA_BITS-1:0] owner_wdata;

    rr_pick #(
        .PORT_NUM (PORT_NUM),
        .IDX_W    (IDX_W)
    ) u_rr_pick (
        .req         (port_req_i),
        .last_winner (last_winner_q),
        .winner      (win)
    );

    // one-hot selection of the winner's command and the owner's write data
    always_comb begin
        win_idx     = '0;
        win_len     = '0;
        win_addr    = '0;
        win_wr      = 1'b0;
        owner_wdata = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (win[p]) begin
                win_idx  = IDX_W'(p);
                win_len  = port_len_i[p*BURST_LEN_W +: BURST_LEN_W];
                win_addr = port_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                win_wr   = port_wr_i[p];
            end
            if (owner_q[p]) begin
                owner_wdata = port_wdata_i[p*MEM_DATA_BITS +: MEM_DATA_BITS];
            end
        end
    end

    // next state; err_d marks a DONE entered by timeout or calibration loss
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (local_init_done_i && (|port_req_i)) state_d = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                if (!local_init_done_i) begin
                    state_d = ARB_DONE;
                    err_d   = 1'b1;
                end else if (len_q == '0) begin
                    state_d = ARB_DONE;
                end else begin
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (!local_init_done_i) begin
                    state_d = ARB_DONE;
                    err_d   = 1'b1;
                end else if (wr_q ? wr_ddr_finish_i : rd_ddr_finish_i) begin
                    state_d = ARB_DONE;
                end else if (wdog_q == '0) begin
                    state_d = ARB_DONE;
                    err_d   = 1'b1;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // state, owner/command latch, round-robin pointer and watchdog down-counter
    always_ff @(posedge ddr_clk_i) begin
        if (!ddr_rst_n_i) begin
            state_q       <= ARB_IDLE;
            err_q         <= 1'b0;
            owner_q       <= '0;
            owner_idx_q   <= '0;
            last_winner_q <= IDX_W'(PORT_NUM - 1);
            len_q         <= '0;
            addr_q        <= '0;
            wr_q          <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == ARB_IDLE && state_d == ARB_ISSUE) begin
                owner_q     <= win;
                owner_idx_q <= win_idx;
                len_q       <= win_len;
                addr_q      <= win_addr;
                wr_q        <= win_wr;
            end
            if (state_q == ARB_ISSUE) begin
                wdog_q <= WDOG_LOAD;
            end else if (state_q == ARB_BUSY && wdog_q != '0) begin
                wdog_q <= wdog_q - 1'b1;
            end
            if (state_q == ARB_DONE) begin
                last_winner_q <= owner_idx_q;
                owner_q       <= '0;
            end
        end
    end

    // outputs decoded from state and owner; everything held at 0 in reset
    always_comb begin
        port_grant_o       = '0;
        port_wdata_req_o   = '0;
        port_rdata_valid_o = '0;
        port_rdata_o       = '0;
        port_done_o        = '0;
        port_err_o         = '0;
        rd_ddr_req_o       = 1'b0;
        rd_ddr_len_o       = '0;
        rd_ddr_addr_o      = '0;
        wr_ddr_req_o       = 1'b0;
        wr_ddr_len_o       = '0;
        wr_ddr_addr_o      = '0;
        wr_ddr_data_o      = '0;
        fwd                = 1'b0;
        if (ddr_rst_n_i) begin
            port_rdata_o = rd_ddr_data_i;
            fwd = (state_q == ARB_BUSY) || (state_q == ARB_ISSUE && len_q != '0);
            if (state_q == ARB_ISSUE || state_q == ARB_BUSY) port_grant_o = owner_q;
            if (state_q == ARB_ISSUE && len_q != '0 && local_init_done_i) begin
                rd_ddr_req_o = !wr_q;
                wr_ddr_req_o = wr_q;
            end
            if (fwd && wr_q) begin
                wr_ddr_len_o  = len_q;
                wr_ddr_addr_o = addr_q;
            end
            if (fwd && !wr_q) begin
                rd_ddr_len_o  = len_q;
                rd_ddr_addr_o = addr_q;
            end
            if (state_q == ARB_BUSY && wr_q) begin
                wr_ddr_data_o    = owner_wdata;
                port_wdata_req_o = owner_q & {PORT_NUM{wr_ddr_data_req_i}};
            end
            if (state_q == ARB_BUSY && !wr_q) begin
                port_rdata_valid_o = owner_q & {PORT_NUM{rd_ddr_data_valid_i}};
            end
            if (state_q == ARB_DONE) begin
                port_done_o = owner_q;
                port_err_o  = err_q ? owner_q : '0;
            end
        end
    end

endmodule
